// File: rtl/keycode_pkg.sv
// Shared types and helpers for the keycode event scheduler: event record,
// FSM state encoding and slot normalisation/membership helpers.
package keycode_pkg;

  localparam logic [7:0] KC_NONE = 8'h00;

  typedef struct packed {
    logic       press;
    logic [7:0] code;
  } kc_evt_t;

  typedef enum logic [2:0] {IDLE, REL0, REL1, PRS0, PRS1, RPT} kc_state_e;

  // A code repeated in slot1 carries no extra information, so slot1 reads as empty.
  function automatic logic [15:0] kc_norm(input logic [15:0] kc);
    kc_norm = (kc[15:8] == kc[7:0]) ? {KC_NONE, kc[7:0]} : kc;
  endfunction

  function automatic logic kc_has(input logic [15:0] kc, input logic [7:0] code);
    kc_has = (kc[7:0] == code) || (kc[15:8] == code);
  endfunction

endpackage

// File: rtl/keycode_event_fifo.sv
// Synchronous event FIFO for the keycode scheduler. A push on a full FIFO is
// accepted only when a pop frees the head slot in the same cycle.
module keycode_event_fifo
  import keycode_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  kc_evt_t                push_data,
  input  logic                   pop,
  output kc_evt_t                pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  kc_evt_t        mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           wr_en;
  logic           rd_en;

  assign empty    = (level == '0);
  assign full     = (level == (AW+1)'(DEPTH));
  assign rd_en    = pop && !empty;
  assign wr_en    = push && (!full || rd_en);
  assign pop_data = mem[rd_ptr];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; occupancy is tracked by the
  // pointers, and a reset on the array would only cost area and routing.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/keycode_event_scheduler.sv
// Turns the two-slot keycode PIO word into an ordered press/release event
// stream. Optional auto-repeat of slot0 under KEYCODE_AUTOREPEAT_EN.
module keycode_event_scheduler
  import keycode_pkg::*;
#(
  parameter int FIFO_DEPTH    = 8,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 2500000
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [15:0]                 keycode_in,
  input  logic                        evt_ready,
  output logic                        evt_valid,
  output logic [7:0]                  evt_code,
  output logic                        evt_press,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  input  logic                        clr_overflow
);

  kc_state_e   state, state_n;
  logic [15:0] kc_q, cur, prev;
  logic        capture;
  logic        push;
  kc_evt_t     push_evt;
  kc_evt_t     head;
  logic        full, empty, pop;
  logic        rpt_due;

`ifdef KEYCODE_AUTOREPEAT_EN
  localparam int HW = $clog2((REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD) + 1);

  logic [HW-1:0] hold_cnt;
  logic          rpt_seen;

  // First repeat waits REPEAT_DELAY from the capture edge; later ones are spaced by REPEAT_PERIOD.
  assign rpt_due = (kc_norm(kc_q) == prev) && (prev[7:0] != KC_NONE) &&
                   (hold_cnt >= (rpt_seen ? HW'(REPEAT_PERIOD - 1) : HW'(REPEAT_DELAY - 1)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt <= '0;
      rpt_seen <= 1'b0;
    end else if (keycode_in != kc_q) begin
      hold_cnt <= '0;
      rpt_seen <= 1'b0;
    end else if (state == IDLE && state_n == RPT) begin
      hold_cnt <= '0;
      rpt_seen <= 1'b1;
    end else if (hold_cnt != '1) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end
`else
  assign rpt_due = 1'b0;
`endif

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n  = state;
    capture  = 1'b0;
    push     = 1'b0;
    push_evt = '{press: 1'b0, code: KC_NONE};
    case (state)
      IDLE: begin
        if (kc_norm(kc_q) != prev) begin
          capture = 1'b1;
          state_n = REL0;
        end else if (rpt_due) begin
          state_n = RPT;
        end
      end
      REL0: begin
        push_evt = '{press: 1'b0, code: prev[7:0]};
        push     = (prev[7:0] != KC_NONE) && !kc_has(cur, prev[7:0]);
        state_n  = REL1;
      end
      REL1: begin
        push_evt = '{press: 1'b0, code: prev[15:8]};
        push     = (prev[15:8] != KC_NONE) && !kc_has(cur, prev[15:8]);
        state_n  = PRS0;
      end
      PRS0: begin
        push_evt = '{press: 1'b1, code: cur[7:0]};
        push     = (cur[7:0] != KC_NONE) && !kc_has(prev, cur[7:0]);
        state_n  = PRS1;
      end
      PRS1: begin
        push_evt = '{press: 1'b1, code: cur[15:8]};
        push     = (cur[15:8] != KC_NONE) && !kc_has(prev, cur[15:8]);
        state_n  = IDLE;
      end
      RPT: begin
        push_evt = '{press: 1'b1, code: prev[7:0]};
        push     = 1'b1;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      kc_q     <= '0;
      cur      <= '0;
      prev     <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_n;
      kc_q  <= keycode_in;
      if (capture) cur <= kc_norm(kc_q);
      if (state == PRS1) prev <= cur;
      // A dropped event in the same cycle as a clear must stay visible.
      if (push && full && !pop) overflow <= 1'b1;
      else if (clr_overflow)    overflow <= 1'b0;
    end
  end

  assign pop = evt_valid && evt_ready;

  keycode_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_evt),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .level     (fifo_level)
  );

  // Unwritten storage is masked so the outputs read zero whenever nothing is queued.
  assign evt_valid = !empty;
  assign evt_code  = empty ? KC_NONE : head.code;
  assign evt_press = !empty && head.press;

endmodule
